// File: rtl/wallace_pp_reduce_pipe_pkg.sv
// wallace_pkg: shared widths, pipeline latency and partial-product weighting.
// PIPE_LAT follows WALLACE_CPA_REG_EN.
package wallace_pkg;
    localparam int PP_W = 17;
    localparam int PP_NUM = 8;
    localparam int OUT_W = 32;
`ifdef WALLACE_CPA_REG_EN
    localparam int PIPE_LAT = 3;
`else
    localparam int PIPE_LAT = 2;
`endif
    typedef logic [OUT_W-1:0] operand_t;
    function automatic operand_t weight(input logic [PP_W-1:0] pp, input int k);
        return operand_t'({{(OUT_W-PP_W){pp[PP_W-1]}}, pp}) << (2 * k);
    endfunction
endpackage

// File: rtl/wallace_pp_reduce_pipe_if.sv
// wallace_pp_reduce_pipe_if: valid/ready bus carrying eight Booth partial products in and the product out.
interface wallace_pp_reduce_pipe_if;
    import wallace_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [PP_W-1:0] PP1, PP2, PP3, PP4, PP5, PP6, PP7, PP8;
    logic out_valid;
    logic out_ready;
    operand_t PRODUCT;
    modport master (
        output in_valid, PP1, PP2, PP3, PP4, PP5, PP6, PP7, PP8, out_ready,
        input in_ready, out_valid, PRODUCT
    );
    modport slave (
        input in_valid, PP1, PP2, PP3, PP4, PP5, PP6, PP7, PP8, out_ready,
        output in_ready, out_valid, PRODUCT
    );
endinterface

// File: rtl/wallace_pp_reduce_pipe_csa.sv
// csa_3_2: 32-bit bitwise 3:2 compressor; carry is pre-shifted left by one and truncated.
module csa_3_2
    import wallace_pkg::*;
(
    input  operand_t a,
    input  operand_t b,
    input  operand_t c,
    output operand_t sum,
    output operand_t carry
);
    assign sum = a ^ b ^ c;
    assign carry = ((a & b) | (a & c) | (b & c)) << 1;
endmodule

// File: rtl/wallace_pp_reduce_pipe.sv
// wallace_pp_reduce_pipe: pipelined Wallace reduction of eight radix-4 Booth partial products to a 32-bit product.
// Define WALLACE_CPA_REG_EN to give the final carry-propagate add its own stage.
module wallace_pp_reduce_pipe
    import wallace_pkg::*;
(
    input logic sys_clk,
    input logic sys_rst_n,
    wallace_pp_reduce_pipe_if.slave bus
);
    logic adv;
    operand_t op [PP_NUM];
    operand_t l1a_s, l1a_c, l1b_s, l1b_c, l2a_s, l2a_c, l2b_s, l2b_c;
    operand_t l3_s, l3_c, fin_s, fin_c;
    operand_t s1 [4];
    logic v1;

    // Single global enable: every stage shifts together, bubbles included.
    assign adv = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = adv;

    assign op[0] = weight(bus.PP1, 0);
    assign op[1] = weight(bus.PP2, 1);
    assign op[2] = weight(bus.PP3, 2);
    assign op[3] = weight(bus.PP4, 3);
    assign op[4] = weight(bus.PP5, 4);
    assign op[5] = weight(bus.PP6, 5);
    assign op[6] = weight(bus.PP7, 6);
    assign op[7] = weight(bus.PP8, 7);

    csa_3_2 u_l1a (.a(op[0]), .b(op[1]), .c(op[2]), .sum(l1a_s), .carry(l1a_c));
    csa_3_2 u_l1b (.a(op[3]), .b(op[4]), .c(op[5]), .sum(l1b_s), .carry(l1b_c));
    csa_3_2 u_l2a (.a(l1a_s), .b(l1a_c), .c(l1b_s), .sum(l2a_s), .carry(l2a_c));
    csa_3_2 u_l2b (.a(l1b_c), .b(op[6]), .c(op[7]), .sum(l2b_s), .carry(l2b_c));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            v1 <= 1'b0;
            s1 <= '{default: '0};
        end else if (adv) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) s1 <= '{l2a_s, l2a_c, l2b_s, l2b_c};
        end
    end

    csa_3_2 u_l3 (.a(s1[0]), .b(s1[1]), .c(s1[2]), .sum(l3_s), .carry(l3_c));
    csa_3_2 u_l4 (.a(l3_s), .b(l3_c), .c(s1[3]), .sum(fin_s), .carry(fin_c));

`ifdef WALLACE_CPA_REG_EN
    operand_t s2_s, s2_c;
    logic v2;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            v2 <= 1'b0;
            s2_s <= '0;
            s2_c <= '0;
            bus.out_valid <= 1'b0;
            bus.PRODUCT <= '0;
        end else if (adv) begin
            v2 <= v1;
            if (v1) begin
                s2_s <= fin_s;
                s2_c <= fin_c;
            end
            bus.out_valid <= v2;
            if (v2) bus.PRODUCT <= s2_s + s2_c;
        end
    end
`else
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.out_valid <= 1'b0;
            bus.PRODUCT <= '0;
        end else if (adv) begin
            bus.out_valid <= v1;
            if (v1) bus.PRODUCT <= fin_s + fin_c;
        end
    end
`endif
endmodule

// File: tb/tb_wallace_pp_reduce_pipe.sv
// tb_wallace_pp_reduce_pipe: directed and streamed checks of the Booth partial-product reducer against A*B.
module tb_wallace_pp_reduce_pipe;
    import wallace_pkg::*;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    wallace_pp_reduce_pipe_if bus();

    wallace_pp_reduce_pipe dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx = 0;
    int first_pop = 0;
    int last_pop = 0;
    logic mon_en = 1'b0;
    logic [31:0] cur_exp = '0;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // Reference radix-4 Booth generator: digit from bits {b[2k+1], b[2k], b[2k-1]}.
    function automatic logic [16:0] booth_pp(input logic [15:0] a, input logic [15:0] b, input int k);
        logic [16:0] ext;
        logic [2:0] g;
        logic signed [17:0] as, m;
        ext = {b, 1'b0};
        g = ext[2*k +: 3];
        as = 18'(signed'(a));
        case (g)
            3'b001, 3'b010: m = as;
            3'b011: m = as <<< 1;
            3'b100: m = -(as <<< 1);
            3'b101, 3'b110: m = -as;
            default: m = '0;
        endcase
        return m[16:0];
    endfunction

    task automatic set_in(input logic [15:0] a, input logic [15:0] b);
        int ai, bi;
        bus.PP1 = booth_pp(a, b, 0);
        bus.PP2 = booth_pp(a, b, 1);
        bus.PP3 = booth_pp(a, b, 2);
        bus.PP4 = booth_pp(a, b, 3);
        bus.PP5 = booth_pp(a, b, 4);
        bus.PP6 = booth_pp(a, b, 5);
        bus.PP7 = booth_pp(a, b, 6);
        bus.PP8 = booth_pp(a, b, 7);
        ai = int'(signed'(a));
        bi = int'(signed'(b));
        cur_exp = 32'(ai * bi);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [31:0] want);
        int lat;
        set_in(a, b);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(PIPE_LAT));
        chk(tag, bus.PRODUCT, want);
        tick();
    endtask

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        if (mon_en && sys_rst_n) begin
            if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("pop_empty", 32'(exp_q.size()), 32'd1);
                else chk("stream_data", bus.PRODUCT, exp_q.pop_front());
                rx++;
                if (rx == 1) first_pop = cyc;
                last_pop = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [15:0] sa [4];
        logic [15:0] sb [4];
        logic [31:0] held;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        set_in(16'h0, 16'h0);
        repeat (3) tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_product", bus.PRODUCT, 32'h0);
        sys_rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        single("p3x5", 16'h0003, 16'h0005, 32'h0000000F);
        single("pmax", 16'h7FFF, 16'h7FFF, 32'h3FFF0001);
        single("pneg1", 16'hFFFF, 16'h0001, 32'hFFFFFFFF);
        single("pmin", 16'h8000, 16'h7FFF, 32'hC0008000);
        single("pm1sq", 16'hFFFF, 16'hFFFF, 32'h00000001);
        single("pzero", 16'h0000, 16'h1234, 32'h00000000);
        single("pbmin", 16'h1234, 16'h8000, 32'hF6E60000);

        mon_en = 1'b1;
        rx = 0;
        for (int i = 0; i < 100; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = 16'($urandom);
            if (a == 16'h8000) a = 16'h8001;
            set_in(a, b);
            bus.in_valid = 1'b1;
            @(negedge sys_clk);
            chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (PIPE_LAT + 2) tick();
        chk("stream_count", 32'(rx), 32'd100);
        chk("stream_rate", 32'(last_pop - first_pop), 32'd99);
        chk("stream_left", 32'(exp_q.size()), 32'd0);

        sa = '{16'h0011, 16'hFF00, 16'h7FFF, 16'h0123};
        sb = '{16'h0022, 16'h0101, 16'h8001, 16'hFEDC};
        rx = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            set_in(sa[i], sb[i]);
            if (i == 0) held = cur_exp;
            bus.in_valid = 1'b1;
            @(negedge sys_clk);
            chk("fill_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
        end
        set_in(sa[3], sb[3]);
        repeat (5) begin
            @(negedge sys_clk);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_product", bus.PRODUCT, held);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (PIPE_LAT + 3) tick();
        chk("drain_count", 32'(rx), 32'(PIPE_LAT + 1));
        chk("drain_left", 32'(exp_q.size()), 32'd0);

        mon_en = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(sa[i], sb[i]);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_product", bus.PRODUCT, 32'h0);
        tick();
        chk("midrst_hold_valid", 32'(bus.out_valid), 32'd0);
        sys_rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) begin
            @(negedge sys_clk);
            chk("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
            chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
        end
        single("post_rst", 16'h0002, 16'hFFFE, 32'hFFFFFFFC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
